// File: rtl/cordic_cos_accumulate.sv
// Streaming accumulator: result = sum_init + sum of cos(x[i]), IEEE-754 single.
// Optional sticky error flag on port err when CORDIC_ACC_ERR_EN is defined.
module cca_cordic_cos (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] x,
  output logic        done,
  output logic [31:0] y
);
  localparam logic signed [31:0] K_INIT  = 32'sd326016437;
  localparam logic signed [31:0] HALF_PI = 32'sd843314857;
  localparam logic signed [31:0] PI      = 32'sd1686629713;

  logic run_q, run_d, neg_q, neg_d, done_q, done_d;
  logic [4:0] it_q, it_d;
  logic signed [31:0] cx_q, cx_d, cy_q, cy_d, cz_q, cz_d, mag;
  logic [31:0] y_q, y_d;
  logic [7:0] ex;
  logic unused_sign;

  assign unused_sign = x[31];
  assign ex = x[30:23];

  function automatic logic signed [31:0] atan_f(input logic [4:0] i);
    case (i)
      5'd0:    return 32'sd421657428;
      5'd1:    return 32'sd248918915;
      5'd2:    return 32'sd131521918;
      5'd3:    return 32'sd66762579;
      5'd4:    return 32'sd33510844;
      5'd5:    return 32'sd16771758;
      5'd6:    return 32'sd8387925;
      5'd7:    return 32'sd4194219;
      default: return 32'sd1 <<< (5'd29 - i);
    endcase
  endfunction

  // Q3.29 fixed point back to single precision
  function automatic logic [31:0] to_f(input logic ng,
                                       input logic signed [31:0] v);
    logic [31:0] m;
    logic [4:0]  p;
    m = v[31] ? 32'(-v) : 32'(v);
    p = 5'd0;
    for (int i = 0; i < 32; i++) if (m[i]) p = 5'(i);
    if (m == 32'd0) return 32'd0;
    return {ng ^ v[31], 8'(8'd98 + 8'(p)),
            23'((m << (5'd31 - p)) >> 8)};
  endfunction

  always_comb begin
    run_d  = run_q;
    neg_d  = neg_q;
    it_d   = it_q;
    cx_d   = cx_q;
    cy_d   = cy_q;
    cz_d   = cz_q;
    y_d    = y_q;
    done_d = 1'b0;
    if (ex > 8'd128)
      mag = PI;
    else if (ex >= 8'd121)
      mag = $signed(32'({1'b1, x[22:0]}) << (ex - 8'd121));
    else
      mag = $signed(32'({1'b1, x[22:0]}) >> (8'd121 - ex));
    if (start) begin
      // cos rounds to exactly 1.0 for |x| < 2^-12
      if (ex < 8'd115) begin
        y_d    = 32'h3F80_0000;
        done_d = 1'b1;
      end else begin
        run_d = 1'b1;
        it_d  = 5'd0;
        cx_d  = K_INIT;
        cy_d  = 32'sd0;
        neg_d = mag > HALF_PI;
        cz_d  = (mag > HALF_PI) ? PI - mag : mag;
      end
    end else if (run_q) begin
      if (cz_q[31]) begin
        cx_d = cx_q + (cy_q >>> it_q);
        cy_d = cy_q - (cx_q >>> it_q);
        cz_d = cz_q + atan_f(it_q);
      end else begin
        cx_d = cx_q - (cy_q >>> it_q);
        cy_d = cy_q + (cx_q >>> it_q);
        cz_d = cz_q - atan_f(it_q);
      end
      it_d = it_q + 5'd1;
      if (it_q == 5'd23) begin
        run_d  = 1'b0;
        done_d = 1'b1;
        y_d    = to_f(neg_q, cx_d);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      neg_q  <= 1'b0;
      done_q <= 1'b0;
      it_q   <= '0;
      cx_q   <= '0;
      cy_q   <= '0;
      cz_q   <= '0;
      y_q    <= '0;
    end else begin
      run_q  <= run_d;
      neg_q  <= neg_d;
      done_q <= done_d;
      it_q   <= it_d;
      cx_q   <= cx_d;
      cy_q   <= cy_d;
      cz_q   <= cz_d;
      y_q    <= y_d;
    end
  end

  assign done = done_q;
  assign y    = y_q;
endmodule

module cca_fp_add (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [31:0] sum
);
  logic        done_q;
  logic [31:0] sum_q, res, big, sml;
  logic [26:0] bx, sx, lost;
  logic [27:0] s;
  logic [7:0]  d;
  logic [4:0]  lz;
  logic signed [9:0] e;
  logic [24:0] m;
  logic        rnd;

  always_comb begin
    big = a;
    sml = b;
    if (b[30:0] > a[30:0]) begin
      big = b;
      sml = a;
    end
    bx = '0; sx = '0; lost = '0; s = '0; d = '0;
    lz = '0; e = '0; m = '0; rnd = 1'b0; res = '0;
    if (a[30:23] == 8'hFF) res = a;
    else if (b[30:23] == 8'hFF) res = b;
    else begin
      if (big[30:23] != 8'd0) bx = {1'b1, big[22:0], 3'b000};
      if (sml[30:23] != 8'd0) sx = {1'b1, sml[22:0], 3'b000};
      d = big[30:23] - sml[30:23];
      if (d > 8'd26) sx = {26'd0, |sx};
      else begin
        lost = sx & ~({27{1'b1}} << d);
        sx   = (sx >> d) | {26'd0, |lost};
      end
      if (big[31] == sml[31]) s = {1'b0, bx} + {1'b0, sx};
      else s = {1'b0, bx} - {1'b0, sx};
      e = $signed({2'b00, big[30:23]});
      if (s[27]) begin
        s = {1'b0, s[27:2], s[1] | s[0]};
        e = e + 10'sd1;
      end else begin
        for (int i = 0; i < 27; i++) if (s[i]) lz = 5'(26 - i);
        s = s << lz;
        e = e - $signed({5'd0, lz});
      end
      rnd = s[2] & (s[3] | s[1] | s[0]);
      m = {1'b0, s[26:3]} + 25'(rnd);
      if (m[24]) begin
        m = m >> 1;
        e = e + 10'sd1;
      end
      if (s == '0 || e <= 10'sd0) res = '0;
      else if (e >= 10'sd255) res = {big[31], 8'hFF, 23'd0};
      else res = {big[31], 8'(e), 23'(m)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      sum_q  <= '0;
    end else begin
      done_q <= en;
      if (en) sum_q <= res;
    end
  end

  assign done = done_q;
  assign sum  = sum_q;
endmodule

module cordic_cos_accumulate #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 8,
  parameter int FLUSH_CYC = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] sum_init,
  input  logic [CNT_W-1:0] count,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             done
`ifdef CORDIC_ACC_ERR_EN
  ,output logic            err
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(FLUSH_CYC) + 1;

  typedef enum logic [2:0] {
    S_FLUSH, S_IDLE, S_FETCH, S_COS_WAIT,
    S_ADD, S_ADD_WAIT, S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [FW-1:0]    flush_q, flush_d;
  logic [WIDTH-1:0] acc_q, acc_d, term_q, term_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] rem_q, rem_d, cnt_q, cnt_d;
  logic [CNT_W-1:0] accd_q, accd_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]      occ_q, occ_d;
  logic             fifo_full, fifo_empty, push, pop;
  logic             cos_done, add_done;
  logic [31:0]      cos_y, add_sum;

  assign busy       = state_q != S_IDLE;
  assign fifo_full  = occ_q == (AW+1)'(DEPTH);
  assign fifo_empty = occ_q == '0;
  assign in_ready   = busy && state_q != S_FLUSH
                      && !fifo_full && accd_q < cnt_q;
  assign push       = in_valid && in_ready;
  assign pop        = state_q == S_FETCH && !fifo_empty;

  cca_cordic_cos u_cos (
    .clk   (clk),
    .rst_n (reset_n),
    .start (pop),
    .x     (mem_q[rp_q]),
    .done  (cos_done),
    .y     (cos_y)
  );

  cca_fp_add u_add (
    .clk   (clk),
    .rst_n (reset_n),
    .en    (state_q == S_ADD),
    .a     (acc_q),
    .b     (term_q),
    .done  (add_done),
    .sum   (add_sum)
  );

  always_comb begin
    state_d  = state_q;
    flush_d  = flush_q;
    acc_d    = acc_q;
    term_d   = term_q;
    result_d = result_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    accd_d   = accd_q;
    done_d   = 1'b0;
    wp_d     = wp_q;
    rp_d     = rp_q;
    occ_d    = occ_q;
    if (push) begin
      wp_d   = wp_q + 1'b1;
      accd_d = accd_q + 1'b1;
    end
    if (pop) rp_d = rp_q + 1'b1;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
    case (state_q)
      S_FLUSH: begin
        if (flush_q == FW'(FLUSH_CYC - 1)) begin
          state_d = S_IDLE;
          flush_d = '0;
        end else flush_d = flush_q + 1'b1;
      end
      S_IDLE: begin
        if (start) begin
          acc_d   = sum_init;
          rem_d   = count;
          cnt_d   = count;
          accd_d  = '0;
          state_d = (count == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: if (!fifo_empty) state_d = S_COS_WAIT;
      S_COS_WAIT: begin
        if (cos_done) begin
          term_d  = cos_y;
          state_d = S_ADD;
        end
      end
      S_ADD: state_d = S_ADD_WAIT;
      S_ADD_WAIT: begin
        if (add_done) begin
          acc_d   = add_sum;
          rem_d   = rem_q - 1'b1;
          state_d = (rem_q == CNT_W'(1)) ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        result_d = acc_q;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_FLUSH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_FLUSH;
      flush_q  <= '0;
      acc_q    <= '0;
      term_q   <= '0;
      result_q <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      accd_q   <= '0;
      done_q   <= 1'b0;
      wp_q     <= '0;
      rp_q     <= '0;
      occ_q    <= '0;
    end else begin
      state_q  <= state_d;
      flush_q  <= flush_d;
      acc_q    <= acc_d;
      term_q   <= term_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      accd_q   <= accd_d;
      done_q   <= done_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= in_data;
  end

  assign result = result_q;
  assign done   = done_q;

`ifdef CORDIC_ACC_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (state_q == S_IDLE && start) err_d = 1'b0;
    if (push && in_data[30:23] == 8'hFF && in_data[22:0] != '0)
      err_d = 1'b1;
    if (state_q == S_ADD_WAIT && add_done && add_sum[30:23] == 8'hFF)
      err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else err_q <= err_d;
  end

  assign err = err_q;
`endif
endmodule

// File: tb/tb_cordic_cos_accumulate.sv
// Directed and randomized checks of cordic_cos_accumulate.
// Tiny angles (|x| < 2^-12) make every cosine term exactly 1.0f.
module tb_cordic_cos_accumulate;
  logic        clk;
  logic        reset_n;
  logic        start;
  logic [31:0] sum_init;
  logic [7:0]  count;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        busy;
  logic [31:0] result;
  logic        done;
`ifdef CORDIC_ACC_ERR_EN
  logic        err;
  logic        done_err;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  int stalls = 0;
  bit ready_seen = 0;
  logic [31:0] done_res = '0;

  cordic_cos_accumulate dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .sum_init (sum_init),
    .count    (count),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .busy     (busy),
    .result   (result),
    .done     (done)
`ifdef CORDIC_ACC_ERR_EN
    ,.err     (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      done_res = result;
      done_cyc = cyc;
`ifdef CORDIC_ACC_ERR_EN
      done_err = err;
`endif
    end
    if (in_ready) ready_seen = 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] int2f(input int v);
    logic [31:0] mm;
    int p;
    if (v == 0) return 32'd0;
    mm = (v < 0) ? 32'(-v) : 32'(v);
    p = 0;
    for (int i = 0; i < 24; i++) if (mm[i]) p = i;
    return {(v < 0), 8'(127 + p), 23'(mm << (23 - p))};
  endfunction

  function automatic logic [31:0] tiny_angle();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(0, 114)),
            23'($urandom)};
  endfunction

  // Reference: every term with |x| < 2^-12 contributes cos(x) = 1.0
  function automatic int term_value(input logic [31:0] x);
    return (x[30:23] < 8'd115) ? 1 : 0;
  endfunction

  task automatic start_job(input logic [31:0] init, input int cnt,
                           output int base);
    @(negedge clk);
    sum_init   = init;
    count      = 8'(cnt);
    start      = 1'b1;
    start_cyc  = cyc;
    base       = done_cnt;
    ready_seen = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w, input int max_wait,
                           output bit ok);
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < max_wait; i++) begin
      if (in_ready) begin
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      if (busy) stalls++;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int base, input int max_wait,
                           input string tag);
    int n;
    n = 0;
    while (done_cnt <= base && n < max_wait) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_finish"}, 32'(done_cnt > base), 32'd1);
  endtask

  task automatic flush_len(output int n);
    n = 0;
    while (n < 500) begin
      @(posedge clk);
      #1;
      n++;
      start = 1'b0;
      if (!busy) break;
    end
  endtask

  initial begin
    int base, n, exp_sum, cnt, init, diff;
    bit ok;
    logic [31:0] w;
    reset_n  = 1'b1;
    start    = 1'b0;
    sum_init = '0;
    count    = '0;
    in_valid = 1'b0;
    in_data  = '0;

    #2 reset_n = 1'b0;
    #1;
    chk("rst_result", result, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
`ifdef CORDIC_ACC_ERR_EN
    chk("rst_err", 32'(err), 32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    start   = 1'b1;
    flush_len(n);
    chk("flush_cycles", 32'(n), 32'd64);
    repeat (5) @(negedge clk);
    chk("flush_start_ignored", 32'(done_cnt), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // 2.0 + cos(0) = 3.0
    start_job(32'h4000_0000, 1, base);
    push_word(32'h0000_0000, 50, ok);
    chk("t1_push", 32'(ok), 32'd1);
    wait_done(base, 200, "t1");
    chk("t1_result", done_res, 32'h4040_0000);
    repeat (3) @(negedge clk);
    chk("t1_one_done", 32'(done_cnt - base), 32'd1);

    // empty job
    start_job(32'h3F80_0000, 0, base);
    wait_done(base, 20, "t2");
    chk("t2_latency", 32'(done_cyc - start_cyc), 32'd2);
    chk("t2_result", done_res, 32'h3F80_0000);
    chk("t2_no_ready", 32'(ready_seen), 32'd0);

    // FIFO fills; the 7th word must be refused
    start_job(32'h0000_0000, 6, base);
    stalls = 0;
    for (int k = 0; k < 6; k++) begin
      push_word(32'h0000_0000, 100, ok);
      chk($sformatf("t3_push%0d", k), 32'(ok), 32'd1);
    end
    chk("t3_full_stall", 32'(stalls > 0), 32'd1);
    push_word(32'h0000_0000, 100, ok);
    chk("t3_extra_refused", 32'(ok), 32'd0);
    wait_done(base, 200, "t3");
    chk("t3_result", done_res, 32'h40C0_0000);

    // cos(pi/3) ~ 0.5 through the full CORDIC path
    start_job(32'h0000_0000, 1, base);
    push_word(32'h3F86_0A91, 50, ok);
    wait_done(base, 200, "cos");
    diff = int'(done_res) - int'(32'h3F00_0000);
    if (diff < 0) diff = -diff;
    chk("cos_pi3_close", 32'(diff <= 2048), 32'd1);

    // abort in COS_WAIT
    start_job(32'h4000_0000, 1, base);
    push_word(32'h3F80_0000, 50, ok);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t4_result", result, 32'd0);
    chk("t4_done", 32'(done), 32'd0);
    chk("t4_in_ready", 32'(in_ready), 32'd0);
    chk("t4_busy", 32'(busy), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    flush_len(n);
    chk("t4_flush_cycles", 32'(n), 32'd64);
    chk("t4_no_done", 32'(done_cnt - base), 32'd0);
    start_job(32'h4000_0000, 1, base);
    push_word(32'h0000_0000, 50, ok);
    wait_done(base, 200, "t4b");
    chk("t4_after_result", done_res, 32'h4040_0000);

    // start held high through the whole job, incl. ADD_WAIT
    start_job(32'h4000_0000, 2, base);
    start    = 1'b1;
    sum_init = 32'h42C8_0000;
    count    = 8'd0;
    push_word(32'h0000_0000, 50, ok);
    push_word(32'h0000_0000, 50, ok);
    n = 0;
    while (done_cnt <= base && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    chk("t5_finish", 32'(done_cnt > base), 32'd1);
    chk("t5_result", done_res, 32'h4080_0000);
    repeat (10) @(negedge clk);
    chk("t5_single_job", 32'(done_cnt - base), 32'd1);
    chk("t5_idle", 32'(busy), 32'd0);

    for (int j = 0; j < 10; j++) begin
      cnt  = $urandom_range(0, 6);
      init = $urandom_range(0, 100) - 50;
      exp_sum = init;
      start_job(int2f(init), cnt, base);
      for (int k = 0; k < cnt; k++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        w = tiny_angle();
        exp_sum += term_value(w);
        push_word(w, 100, ok);
        if (!ok) chk($sformatf("rnd%0d_push", j), 32'(ok), 32'd1);
      end
      wait_done(base, 300, $sformatf("rnd%0d", j));
      chk($sformatf("rnd%0d_result", j), done_res, int2f(exp_sum));
    end

`ifdef CORDIC_ACC_ERR_EN
    start_job(32'h0000_0000, 1, base);
    push_word(32'h7FC0_0000, 50, ok);
    wait_done(base, 200, "t6");
    chk("t6_err_set", 32'(done_err), 32'd1);
    start_job(32'h3F80_0000, 0, base);
    wait_done(base, 20, "t6b");
    chk("t6_err_clear", 32'(done_err), 32'd0);
    chk("t6b_result", done_res, 32'h3F80_0000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
